// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding used by both initiator and
// responder FSMs, and width helpers for strobes and watchdog counters.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // One strobe bit per byte lane.
    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    // Counter wide enough to hold 0..limit; never narrower than one bit so a
    // disabled watchdog (limit 0) still elaborates.
    function automatic int wdog_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_master_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches limit-1. A limit of 0 never expires.
module apb_master_watchdog #(
    parameter int CNT_WIDTH = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [CNT_WIDTH-1:0] i_limit,
    output logic                 o_expired
);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_armed;
    logic                 w_last;

    assign w_armed   = (i_limit != '0);
    assign w_last    = (r_count == (i_limit - CNT_WIDTH'(1)));
    assign o_expired = i_enable && w_armed && w_last;

    // Count enabled cycles; clear takes priority so a new window starts at 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB initiator: accepts one valid/ready command, runs a single APB
// SETUP/ACCESS transfer on the tim_* bus and holds the response until it is
// consumed. A watchdog aborts ACCESS phases that never see PREADY.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. cmd_ready may depend combinationally on rsp_ready (RESP
// state) so a response can be retired and the next command taken in the same
// cycle; rsp_valid and the response fields are held stable until rsp_ready.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    // command channel
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    // response channel
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    // APB bus
    output logic                    tim_psel,
    output logic                    tim_penable,
    output logic                    tim_pwrite,
    output logic [ADDR_WIDTH-1:0]   tim_paddr,
    output logic [DATA_WIDTH-1:0]   tim_pwdata,
    output logic [DATA_WIDTH/8-1:0] tim_pstrb,
    input  logic [DATA_WIDTH-1:0]   tim_prdata,
    input  logic                    tim_pready,
    input  logic                    tim_pslverr
);

    localparam int                STRB_W   = strb_width(DATA_WIDTH);
    localparam int                CNT_W    = wdog_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    apb_state_e          r_state;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic                r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_rsp_timeout;

    logic                w_cmd_ready;
    logic                w_accept;
    logic                w_wd_clear;
    logic                w_wd_enable;
    logic                w_wd_expired;

    // A command can be taken when idle, or in RESP in the same cycle the
    // pending response is consumed (back-to-back with no IDLE bubble).
    assign w_cmd_ready = (r_state == ST_IDLE) ||
                         ((r_state == ST_RESP) && rsp_ready);
    assign w_accept    = cmd_valid && w_cmd_ready;

    // SETUP always precedes ACCESS, so clearing there restarts the window
    // exactly on entry to ACCESS.
    assign w_wd_clear  = (r_state == ST_SETUP);
    assign w_wd_enable = (r_state == ST_ACCESS);

    apb_master_watchdog #(
        .CNT_WIDTH (CNT_W)
    ) u_watchdog (
        .i_clk     (sys_clk),
        .i_rst     (sys_rst),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .i_limit   (WD_LIMIT),
        .o_expired (w_wd_expired)
    );

    // Transfer FSM with registered APB and response outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // command capture handled below
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY beats the watchdog when both land in one cycle.
                    if (tim_pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= tim_pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= r_pwrite ? '0 : tim_prdata;
                        r_state       <= ST_RESP;
                    end else if (w_wd_expired) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Accepting a command overrides the IDLE fall-through of RESP.
            if (w_accept) begin
                r_pwrite  <= cmd_write;
                r_paddr   <= cmd_addr;
                r_pwdata  <= cmd_wdata;
                r_pstrb   <= cmd_write ? cmd_strb : '0;
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_state   <= ST_SETUP;
            end
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign tim_psel    = r_psel;
    assign tim_penable = r_penable;
    assign tim_pwrite  = r_pwrite;
    assign tim_paddr   = r_paddr;
    assign tim_pwdata  = r_pwdata;
    assign tim_pstrb   = r_pstrb;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed cases for the documented corner cases plus
// randomized transfers against a transaction-level reference model.
module tb_apb_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;
    localparam int RW = DW + 2;

    // ---------------- clock / reset ----------------
    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          tim_psel;
    logic          tim_penable;
    logic          tim_pwrite;
    logic [AW-1:0] tim_paddr;
    logic [DW-1:0] tim_pwdata;
    logic [SW-1:0] tim_pstrb;
    logic [DW-1:0] tim_prdata;
    logic          tim_pready;
    logic          tim_pslverr;

    always #5 sys_clk = ~sys_clk;

    apb_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .tim_psel    (tim_psel),
        .tim_penable (tim_penable),
        .tim_pwrite  (tim_pwrite),
        .tim_paddr   (tim_paddr),
        .tim_pwdata  (tim_pwdata),
        .tim_pstrb   (tim_pstrb),
        .tim_prdata  (tim_prdata),
        .tim_pready  (tim_pready),
        .tim_pslverr (tim_pslverr)
    );

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    // wait_n = number of ACCESS cycles the responder holds PREADY low.
    function automatic bit model_timeout(input int wait_n);
        return (TO != 0) && (wait_n >= TO);
    endfunction

    function automatic int model_access(input int wait_n);
        return model_timeout(wait_n) ? TO : wait_n + 1;
    endfunction

    // Response packed as {timeout, err, rdata}.
    function automatic logic [RW-1:0] model_rsp(input bit wr, input int wait_n,
                                                input bit slverr, input logic [DW-1:0] rdata);
        bit            to;
        logic [DW-1:0] rd;
        to = model_timeout(wait_n);
        rd = (wr || to) ? '0 : rdata;
        return {to, (to || slverr), rd};
    endfunction

    // ---------------- driver tasks ----------------
    // Starts at a negedge. If b2b, the previous response is still pending and
    // is retired in the same cycle the new command is offered. Acts as the APB
    // responder while the transfer runs and leaves the response pending.
    task automatic run_xfer(input string name, input bit wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                            input int wait_n, input bit slverr, input logic [DW-1:0] rdata,
                            input int hold, input bit b2b);
        int            cyc;
        int            n_psel;
        int            n_pen;
        int            n_bad;
        int            acc;
        bit            rdy;
        logic [RW-1:0] exp_rsp;
        logic [RW-1:0] got;
        logic [SW-1:0] exp_strb;
        exp_strb  = wr ? strb : '0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        rsp_ready = b2b;
        #1;
        check_eq({name, ":cmd_ready"}, 64'(cmd_ready), 64'd1);
        exp_q.push_back(model_rsp(wr, wait_n, slverr, rdata));
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cyc = 1; n_psel = 0; n_pen = 0; n_bad = 0; acc = 0;
        check_eq({name, ":setup_next"}, 64'({tim_psel, tim_penable}), 64'b10);
        while (!rsp_valid && cyc < 64) begin
            if (tim_psel) begin
                n_psel++;
                if (tim_paddr !== addr || tim_pwrite !== wr ||
                    tim_pwdata !== wdata || tim_pstrb !== exp_strb) n_bad++;
            end
            if (tim_penable) n_pen++;
            if (tim_psel && tim_penable) begin
                rdy         = (acc == wait_n);
                tim_pready  = rdy;
                tim_pslverr = rdy ? slverr : 1'($urandom_range(0, 1));
                tim_prdata  = rdy ? rdata : DW'($urandom);
                acc++;
            end else begin
                tim_pready  = 1'b0;
                tim_pslverr = 1'($urandom_range(0, 1));
                tim_prdata  = DW'($urandom);
            end
            @(negedge sys_clk);
            cyc++;
        end
        tim_pready = 1'b0;
        check_eq({name, ":rsp_valid"}, 64'(rsp_valid), 64'd1);
        check_eq({name, ":latency"}, 64'(cyc), 64'(2 + model_access(wait_n)));
        check_eq({name, ":psel_cycles"}, 64'(n_psel), 64'(1 + model_access(wait_n)));
        check_eq({name, ":penable_cycles"}, 64'(n_pen), 64'(model_access(wait_n)));
        check_eq({name, ":bus_stable"}, 64'(n_bad), 64'd0);
        check_eq({name, ":bus_idle"}, 64'({tim_psel, tim_penable}), 64'b00);
        got = {rsp_timeout, rsp_err, rsp_rdata};
        exp_rsp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check_eq({name, ":rsp"}, 64'(got), 64'(exp_rsp));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            @(negedge sys_clk);
            check_eq({name, ":hold_valid"}, 64'(rsp_valid), 64'd1);
            check_eq({name, ":hold_ready"}, 64'(cmd_ready), 64'd0);
            check_eq({name, ":hold_rsp"}, 64'({rsp_timeout, rsp_err, rsp_rdata}), 64'(got));
        end
        cmd_valid = 1'b0;
    endtask

    // Retires a pending response with no follow-on command.
    task automatic drain(input string name);
        rsp_ready = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        rsp_ready = 1'b0;
        check_eq({name, ":drain_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({name, ":drain_idle"}, 64'({cmd_ready, tim_psel}), 64'b10);
    endtask

    // Asserts reset between clock edges while a read sits in ACCESS.
    task automatic reset_mid_access();
        int n;
        bit saw_access;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h0A0;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
        tim_pready = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(tim_psel && tim_penable) && n < 8) begin
            @(negedge sys_clk);
            n++;
        end
        @(negedge sys_clk);
        saw_access = tim_psel && tim_penable;
        check_eq("rst:in_access", 64'(saw_access), 64'd1);
        #2 sys_rst = 1'b1;
        #1;
        check_eq("rst:async_bus", 64'({tim_psel, tim_penable}), 64'b00);
        check_eq("rst:no_rsp", 64'(rsp_valid), 64'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        check_eq("rst:cmd_ready", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 3; i++) @(negedge sys_clk);
        check_eq("rst:still_no_rsp", 64'({rsp_valid, tim_psel}), 64'b00);
    endtask

    // ---------------- stimulus ----------------
    bit            pending;
    bit            r_wr;
    bit            r_b2b;
    bit            r_err;
    int            r_wait;
    int            r_sel;

    initial begin
        sys_rst     = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        cmd_strb    = '0;
        rsp_ready   = 1'b0;
        tim_prdata  = '0;
        tim_pready  = 1'b0;
        tim_pslverr = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_eq("reset:psel",    64'(tim_psel), 64'd0);
        check_eq("reset:penable", 64'(tim_penable), 64'd0);
        check_eq("reset:pwrite",  64'(tim_pwrite), 64'd0);
        check_eq("reset:paddr",   64'(tim_paddr), 64'd0);
        check_eq("reset:pwdata",  64'(tim_pwdata), 64'd0);
        check_eq("reset:pstrb",   64'(tim_pstrb), 64'd0);
        check_eq("reset:rsp",     64'({rsp_valid, rsp_timeout, rsp_err, rsp_rdata}), 64'd0);
        sys_rst = 1'b0;
        #1;
        check_eq("reset:cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge sys_clk);

        // zero-wait write
        run_xfer("wr0", 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'hCAFEF00D, 0, 1'b0);
        drain("wr0");
        // read, three wait states, strobes on a read must be dropped
        run_xfer("rd3", 1'b0, 12'h010, 32'h55AA55AA, 4'hA, 3, 1'b0, 32'h12345678, 0, 1'b0);
        drain("rd3");
        // slave error, then a normal command
        run_xfer("slverr", 1'b1, 12'h020, 32'h0000_1111, 4'h3, 1, 1'b1, 32'h0, 0, 1'b0);
        drain("slverr");
        run_xfer("after_err", 1'b0, 12'h024, 32'h0, 4'h0, 0, 1'b0, 32'hA5A5_0001, 0, 1'b0);
        drain("after_err");
        // responder never ready, then ready on the last allowed cycle
        run_xfer("timeout", 1'b0, 12'h030, 32'h0, 4'h0, 40, 1'b0, 32'h7777_7777, 0, 1'b0);
        drain("timeout");
        run_xfer("edge15", 1'b0, 12'h034, 32'h0, 4'h0, TO - 1, 1'b0, 32'h8888_0002, 0, 1'b0);
        drain("edge15");
        // back-pressure then back-to-back
        run_xfer("bp", 1'b1, 12'h040, 32'h0BAD_F00D, 4'h5, 0, 1'b0, 32'h0, 5, 1'b0);
        run_xfer("b2b", 1'b0, 12'h044, 32'h0, 4'hF, 2, 1'b0, 32'h0F0F_0F0F, 2, 1'b1);
        drain("b2b");
        // reset in the middle of ACCESS, then a fresh read
        reset_mid_access();
        run_xfer("post_rst", 1'b0, 12'h0A4, 32'h0, 4'h0, 1, 1'b0, 32'h3141_5926, 0, 1'b0);
        drain("post_rst");

        // randomized transfers
        pending = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r_wr  = 1'($urandom_range(0, 1));
            r_err = ($urandom_range(0, 3) == 0);
            r_sel = $urandom_range(0, 9);
            if (r_sel == 0)      r_wait = $urandom_range(TO - 2, TO + 1);
            else if (r_sel == 1) r_wait = $urandom_range(5, 10);
            else                 r_wait = $urandom_range(0, 3);
            r_b2b = pending && ($urandom_range(0, 1) == 1);
            if (pending && !r_b2b) drain($sformatf("rnd%0d", i));
            run_xfer($sformatf("rnd%0d", i), r_wr, AW'($urandom), DW'($urandom), SW'($urandom),
                     r_wait, r_err, DW'($urandom), $urandom_range(0, 3), r_b2b);
            pending = 1'b1;
        end
        if (pending) drain("rnd_end");

        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #500000;
        $display("FAIL sim_timeout: got stalled run expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
